// File: rtl/ucie_ctl_rx_buffer_ctrl.sv
// RX buffer sequencing/flow controller: gates the buffer from link state, mirrors
// occupancy, returns one credit per drained flit and drains cleanly on link-down.
module ucie_ctl_rx_buffer_ctrl #(
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 3,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int TMO_W         = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_link_up,
  input  logic             i_rdi_pl_valid,
  input  logic             i_fdi_data_valid,
  input  logic             i_overflow_detected,
  input  logic             i_err_clear,
  output logic             o_buffer_en,
  output logic             o_buffer_flush,
  output logic [CNT_W-1:0] o_occupancy,
  output logic [CNT_W-1:0] o_credit_avail,
  output logic             o_credit_return,
  output logic             o_drain_done,
  output logic             o_error,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(DRAIN_TIMEOUT);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] occ_reg, occ_next;
  logic [TMO_W-1:0] timer_reg, timer_next;
  logic             buffer_en_reg;
  logic             flush_reg, flush_next;
  logic             credit_ret_reg, credit_ret_next;
  logic             drain_done_reg, drain_done_next;
  logic [CNT_W-1:0] credit_avail_reg;

  logic             wr, rd;
  logic [CNT_W-1:0] occ_upd;

  assign wr = i_rdi_pl_valid & buffer_en_reg;
  assign rd = i_fdi_data_valid;

  // Net occupancy change; simultaneous wr and rd cancel.
  always_comb begin
    occ_upd = occ_reg;
    if (wr && !rd)
      occ_upd = occ_reg + CNT_W'(1);
    else if (rd && !wr)
      occ_upd = occ_reg - CNT_W'(1);
  end

  always_comb begin
    state_next      = state_reg;
    occ_next        = occ_reg;
    timer_next      = timer_reg;
    flush_next      = 1'b0;
    drain_done_next = 1'b0;
    credit_ret_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        occ_next = '0;
        if (i_link_up)
          state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        credit_ret_next = rd;
        // Error conditions outrank link-down; occupancy is frozen on error entry.
        if (i_overflow_detected ||
            (wr && !rd && occ_reg == DEPTH_C) ||
            (rd && !wr && occ_reg == '0)) begin
          state_next = ST_ERROR;
        end else begin
          occ_next = occ_upd;
          if (!i_link_up) begin
            state_next = ST_DRAIN;
            timer_next = '0;
          end
        end
      end
      ST_DRAIN: begin
        credit_ret_next = rd;
        timer_next      = timer_reg + TMO_W'(1);
        if (wr || (rd && occ_reg == '0)) begin
          state_next = ST_ERROR;
        end else begin
          occ_next = occ_upd;
          if (occ_upd == '0) begin
            state_next      = ST_IDLE;
            drain_done_next = 1'b1;
          end else if (timer_reg == TMO_C) begin
            state_next = ST_ERROR;
          end
        end
      end
      default: begin
        if (i_err_clear) begin
          state_next = ST_IDLE;
          occ_next   = '0;
          flush_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg        <= ST_IDLE;
      occ_reg          <= '0;
      timer_reg        <= '0;
      buffer_en_reg    <= 1'b0;
      flush_reg        <= 1'b0;
      credit_ret_reg   <= 1'b0;
      drain_done_reg   <= 1'b0;
      credit_avail_reg <= DEPTH_C;
    end else begin
      state_reg        <= state_next;
      occ_reg          <= occ_next;
      timer_reg        <= timer_next;
      buffer_en_reg    <= (state_next == ST_ACTIVE) || (state_next == ST_DRAIN);
      flush_reg        <= flush_next;
      credit_ret_reg   <= credit_ret_next;
      drain_done_reg   <= drain_done_next;
      credit_avail_reg <= DEPTH_C - occ_next;
    end
  end

  assign o_buffer_en     = buffer_en_reg;
  assign o_buffer_flush  = flush_reg;
  assign o_occupancy     = occ_reg;
  assign o_credit_avail  = credit_avail_reg;
  assign o_credit_return = credit_ret_reg;
  assign o_drain_done    = drain_done_reg;
  assign o_error         = (state_reg == ST_ERROR);
  assign o_state         = state_reg;

endmodule

// File: tb/tb_ucie_ctl_rx_buffer_ctrl.sv
// Directed bench for ucie_ctl_rx_buffer_ctrl with hand-computed expectations.
module tb_ucie_ctl_rx_buffer_ctrl;

  logic       clk;
  logic       rst;
  logic       link_up;
  logic       rdi_pl_valid;
  logic       fdi_data_valid;
  logic       overflow_detected;
  logic       err_clear;
  logic       buffer_en;
  logic       buffer_flush;
  logic [2:0] occupancy;
  logic [2:0] credit_avail;
  logic       credit_return;
  logic       drain_done;
  logic       error;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  ucie_ctl_rx_buffer_ctrl dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_link_up           (link_up),
    .i_rdi_pl_valid      (rdi_pl_valid),
    .i_fdi_data_valid    (fdi_data_valid),
    .i_overflow_detected (overflow_detected),
    .i_err_clear         (err_clear),
    .o_buffer_en         (buffer_en),
    .o_buffer_flush      (buffer_flush),
    .o_occupancy         (occupancy),
    .o_credit_avail      (credit_avail),
    .o_credit_return     (credit_return),
    .o_drain_done        (drain_done),
    .o_error             (error),
    .o_state             (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; link_up = 1'b0; rdi_pl_valid = 1'b0; fdi_data_valid = 1'b0;
    overflow_detected = 1'b0; err_clear = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_en", buffer_en, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_avail", credit_avail, 4);
    chk("rst_error", error, 0);
    chk("rst_flush", buffer_flush, 0);

    // Link up -> ACTIVE one cycle later
    link_up = 1'b1;
    step();
    chk("up_state", state, 1);
    chk("up_en", buffer_en, 1);
    chk("up_avail", credit_avail, 4);

    // Fill to DEPTH, then overflow
    rdi_pl_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("full_occ", occupancy, 4);
    chk("full_avail", credit_avail, 0);
    chk("full_state", state, 1);
    step();
    rdi_pl_valid = 1'b0;
    chk("ovf_state", state, 3);
    chk("ovf_error", error, 1);
    chk("ovf_en", buffer_en, 0);
    chk("ovf_occ_frozen", occupancy, 4);

    // Clear error -> IDLE with flush pulse, then ACTIVE again
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_flush", buffer_flush, 1);
    chk("clr_occ", occupancy, 0);
    chk("clr_avail", credit_avail, 4);
    step();
    chk("clr_flush_end", buffer_flush, 0);
    chk("reup_state", state, 1);

    // Occupancy 2, then simultaneous wr&rd for 3 cycles
    rdi_pl_valid = 1'b1;
    step(); step();
    chk("two_occ", occupancy, 2);
    fdi_data_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(credit_return);
      chk("wrrd_occ", occupancy, 2);
    end
    rdi_pl_valid = 1'b0; fdi_data_valid = 1'b0;
    step();
    pulses += int'(credit_return);
    chk("wrrd_credits", pulses, 3);
    chk("wrrd_avail", credit_avail, 2);

    // Occupancy 3, link down, drain with 3 reads
    rdi_pl_valid = 1'b1;
    step();
    rdi_pl_valid = 1'b0;
    chk("three_occ", occupancy, 3);
    link_up = 1'b0;
    step();
    chk("drain_state", state, 2);
    chk("drain_en", buffer_en, 1);
    fdi_data_valid = 1'b1;
    pulses = 0;
    step(); pulses += int'(drain_done);
    chk("drain_occ2", occupancy, 2);
    step(); pulses += int'(drain_done);
    step(); pulses += int'(drain_done);
    fdi_data_valid = 1'b0;
    chk("drained_state", state, 0);
    chk("drained_occ", occupancy, 0);
    chk("drained_en", buffer_en, 0);
    step(); pulses += int'(drain_done);
    chk("drain_done_count", pulses, 1);

    // Drain timeout: occupancy 2, no reads; link_up return is ignored
    link_up = 1'b1;
    step();
    rdi_pl_valid = 1'b1;
    step(); step();
    rdi_pl_valid = 1'b0;
    link_up = 1'b0;
    step();
    chk("tmo_drain", state, 2);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) link_up = 1'b1;
      step();
    end
    chk("tmo_still_drain", state, 2);
    step();
    chk("tmo_state", state, 3);
    chk("tmo_error", error, 1);
    chk("tmo_occ", occupancy, 2);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("tmo_clr_state", state, 0);
    chk("tmo_clr_flush", buffer_flush, 1);
    chk("tmo_clr_avail", credit_avail, 4);
    step();
    chk("tmo_reup", state, 1);

    // Underflow read in ACTIVE
    fdi_data_valid = 1'b1;
    step();
    fdi_data_valid = 1'b0;
    chk("udf_state", state, 3);
    chk("udf_credit", credit_return, 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    chk("udf_reup", state, 1);

    // Write during DRAIN -> ERROR
    rdi_pl_valid = 1'b1;
    step();
    rdi_pl_valid = 1'b0;
    link_up = 1'b0;
    step();
    chk("dwr_drain", state, 2);
    rdi_pl_valid = 1'b1;
    step();
    rdi_pl_valid = 1'b0;
    chk("dwr_state", state, 3);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    link_up = 1'b1;
    step();
    chk("dwr_reup", state, 1);

    // Reset while in DRAIN: back to reset values, no drain/flush pulse
    rdi_pl_valid = 1'b1;
    step();
    rdi_pl_valid = 1'b0;
    link_up = 1'b0;
    step();
    chk("rstd_drain", state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstd_state", state, 0);
    chk("rstd_done", drain_done, 0);
    chk("rstd_flush", buffer_flush, 0);
    chk("rstd_occ", occupancy, 0);
    chk("rstd_avail", credit_avail, 4);
    step();
    chk("rstd_done_after", drain_done, 0);
    chk("rstd_idle", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
